// File: rtl/axis_mux_pkg.sv
// Shared definitions for the AXI-Stream mux select controller:
// FSM state encodings and default parameter values.
package axis_mux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_IN_PKT = 2'd1,
      ST_SWITCH = 2'd2
   } state_t;

   localparam int DEF_TIMEOUT_CYCLES = 1024;
   localparam int DEF_CW             = 32;

endpackage

// File: rtl/cdc_bit_sync.sv
// Two-flop synchronizer for a single quasi-static bit.
// Both stages clear on asynchronous active-high reset.
module cdc_bit_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/axis_mux_select_ctrl.sv
// Select controller for a two-input AXI-Stream mux: switches only
// between packets while the output is idle, and flags mid-packet stalls.
module axis_mux_select_ctrl
   import axis_mux_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CW             = DEF_CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_select,
   input  logic          mon_tvalid,
   input  logic          mon_tready,
   input  logic          mon_tlast,
   output logic          input_select,
   output logic          switch_pending,
   output logic          in_packet,
   output logic          stall_flag,
   output logic [CW-1:0] switch_count
);

   localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

   state_t        state;
   logic          req_sync;
   logic          beat;
   logic          differ;
   logic [CW-1:0] stall_timer;

   cdc_bit_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (req_select),
      .q     (req_sync)
   );

   assign beat   = mon_tvalid & mon_tready;
   assign differ = req_sync != input_select;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         input_select   <= 1'b0;
         switch_pending <= 1'b0;
         in_packet      <= 1'b0;
         stall_flag     <= 1'b0;
         switch_count   <= '0;
         stall_timer    <= '0;
      end else begin
         switch_pending <= differ;
         unique case (state)
            ST_IDLE: begin
               stall_timer <= '0;
               if (beat && !mon_tlast) begin
                  state     <= ST_IN_PKT;
                  in_packet <= 1'b1;
               end else if (!mon_tvalid && differ) begin
                  // Select moves on entry so SWITCH is the single dead cycle
                  state        <= ST_SWITCH;
                  input_select <= req_sync;
                  switch_count <= switch_count + 1'b1;
               end
            end
            ST_IN_PKT: begin
               if (beat) begin
                  stall_timer <= '0;
                  if (mon_tlast) begin
                     state     <= ST_IDLE;
                     in_packet <= 1'b0;
                  end
               end else if (stall_timer != TMO) begin
                  stall_timer <= stall_timer + 1'b1;
                  if (stall_timer == TMO - 1'b1)
                     stall_flag <= 1'b1;
               end
            end
            ST_SWITCH: begin
               state       <= ST_IDLE;
               stall_timer <= '0;
            end
            default: begin
               state       <= ST_IDLE;
               in_packet   <= 1'b0;
               stall_timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_mux_select_ctrl.sv
// Directed bench for axis_mux_select_ctrl with hand-computed
// expectations; inputs change 1 time unit after each rising edge.
module tb_axis_mux_select_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_select = 1'b0;
   logic        mon_tvalid = 1'b0;
   logic        mon_tready = 1'b0;
   logic        mon_tlast = 1'b0;
   logic        input_select;
   logic        switch_pending;
   logic        in_packet;
   logic        stall_flag;
   logic [31:0] switch_count;

   int total = 0;
   int bad   = 0;

   axis_mux_select_ctrl #(
      .TIMEOUT_CYCLES (1024),
      .CW             (32)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req_select     (req_select),
      .mon_tvalid     (mon_tvalid),
      .mon_tready     (mon_tready),
      .mon_tlast      (mon_tlast),
      .input_select   (input_select),
      .switch_pending (switch_pending),
      .in_packet      (in_packet),
      .stall_flag     (stall_flag),
      .switch_count   (switch_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic r, input logic l);
      mon_tvalid = v;
      mon_tready = r;
      mon_tlast  = l;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_select = 1'b0;
      drive(0, 0, 0);
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      // reset state
      do_reset();
      chk("rst_sel", 32'(input_select), 0);
      chk("rst_pend", 32'(switch_pending), 0);
      chk("rst_inpkt", 32'(in_packet), 0);
      chk("rst_stall", 32'(stall_flag), 0);
      chk("rst_cnt", switch_count, 0);
      tick();
      chk("first_edge_inpkt", 32'(in_packet), 0);

      // idle switch: select flips on 3rd edge
      req_select = 1'b1;
      tick(2);
      chk("idle_sel_e2", 32'(input_select), 0);
      tick();
      chk("idle_sel_e3", 32'(input_select), 1);
      chk("idle_cnt", switch_count, 1);
      tick();
      chk("idle_pend_clr", 32'(switch_pending), 0);

      // request during beat 2 of 8-beat packet
      do_reset();
      drive(1, 1, 0);
      tick();
      chk("pkt_inpkt", 32'(in_packet), 1);
      req_select = 1'b1;
      tick(6);
      chk("pkt_sel_hold", 32'(input_select), 0);
      chk("pkt_pend", 32'(switch_pending), 1);
      drive(1, 1, 1);
      tick();
      chk("pkt_last_inpkt", 32'(in_packet), 0);
      chk("pkt_last_sel", 32'(input_select), 0);
      drive(0, 0, 0);
      tick();
      chk("pkt_after_sel", 32'(input_select), 1);
      chk("pkt_after_cnt", switch_count, 1);

      // request glitch mid-packet
      do_reset();
      drive(1, 1, 0);
      tick();
      req_select = 1'b1;
      tick();
      req_select = 1'b0;
      tick(3);
      drive(1, 1, 1);
      tick();
      drive(0, 0, 0);
      tick(3);
      chk("glitch_cnt", switch_count, 0);
      chk("glitch_pend", 32'(switch_pending), 0);
      chk("glitch_sel", 32'(input_select), 0);

      // stall timeout
      do_reset();
      drive(1, 1, 0);
      tick();
      drive(1, 0, 0);
      tick(1023);
      chk("stall_1023", 32'(stall_flag), 0);
      tick();
      chk("stall_1024", 32'(stall_flag), 1);
      drive(1, 1, 1);
      tick();
      chk("stall_end_inpkt", 32'(in_packet), 0);
      drive(0, 0, 0);
      tick(2);
      chk("stall_sticky", 32'(stall_flag), 1);

      // async reset mid-packet with select=1
      do_reset();
      req_select = 1'b1;
      tick(4);
      chk("ar_sel_pre", 32'(input_select), 1);
      drive(1, 1, 0);
      tick(2);
      chk("ar_inpkt_pre", 32'(in_packet), 1);
      req_select = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("ar_sel", 32'(input_select), 0);
      chk("ar_inpkt", 32'(in_packet), 0);
      chk("ar_cnt", switch_count, 0);
      drive(0, 0, 0);
      tick();
      reset = 1'b0;
      tick();
      chk("ar_post_inpkt", 32'(in_packet), 0);

      // back-to-back single-beat packets block switch
      do_reset();
      drive(1, 1, 1);
      req_select = 1'b1;
      tick(6);
      chk("b2b_sel", 32'(input_select), 0);
      chk("b2b_inpkt", 32'(in_packet), 0);
      chk("b2b_pend", 32'(switch_pending), 1);
      drive(0, 0, 0);
      tick();
      chk("b2b_sel_after", 32'(input_select), 1);
      chk("b2b_cnt", switch_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
